piece_motion_sched: RTL

Frame-synchronous motion scheduler for the falling Tetris piece. It owns the piece reference position (`ref_x`, `ref_y`) that drives the VGA pixel/colour logic. Once per video frame it arbitrates button requests against the gravity tick and applies collision vetoes from the shape logic. It also sequences lock, row-clear wait, respawn and game-over.

---
 rtl/tetris_pkg.sv | 21 ++
 rtl/btn_sync_edge.sv | 30 +++
 rtl/piece_motion_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: scheduler FSM states and board geometry.
package tetris_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        SETTLE,
        FALL,
        LOCK,
        WAITCLR,
        SPAWN,
        OVER
    } state_t;

    localparam int STEP    = 20;
    localparam int X_MIN   = 220;
    localparam int X_MAX   = 400;
    localparam int X_START = 300;
    localparam int Y_START = 0;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronise the raw input and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/piece_motion_sched.sv
// Frame-synchronous motion scheduler for the falling piece: button moves,
// gravity, lock, row-clear wait, respawn and game-over sequencing.
module piece_motion_sched
    import tetris_pkg::*;
#(
    parameter int STEP        = tetris_pkg::STEP,
    parameter int X_MIN       = tetris_pkg::X_MIN,
    parameter int X_MAX       = tetris_pkg::X_MAX,
    parameter int X_START     = tetris_pkg::X_START,
    parameter int Y_START     = tetris_pkg::Y_START,
    parameter int GRAV_FRAMES = 30,
    parameter int FAST_FRAMES = 3
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       vs,
    input  logic       up,
    input  logic       left,
    input  logic       down,
    input  logic       right,
    input  logic       start_over,
    input  logic       blk_left,
    input  logic       blk_right,
    input  logic       blk_below,
    input  logic       blk_rot,
    input  logic       clear,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic       rotate,
    output logic       lock,
    output logic       spawn,
    output logic       game_over
);

    localparam logic [9:0] STEP_V    = 10'(STEP);
    localparam logic [9:0] X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0] X_MAX_V   = 10'(X_MAX);
    localparam logic [9:0] X_START_V = 10'(X_START);
    localparam logic [9:0] Y_START_V = 10'(Y_START);
    localparam logic [7:0] GRAV_LIM  = 8'(GRAV_FRAMES - 1);
    localparam logic [7:0] FAST_LIM  = 8'(FAST_FRAMES - 1);

    state_t     state;
    logic [7:0] grav_cnt;
    logic [7:0] grav_lim;
    logic       grav_due;
    logic       pend_rot;
    logic       pend_left;
    logic       pend_right;
    logic       vs_d;
    logic       frame_start;

    logic lvl_up, lvl_left, lvl_down, lvl_right, lvl_so;
    logic rise_up, rise_left, rise_down, rise_right, rise_so;
    logic unused_sync;

    btn_sync_edge u_sync_up (
        .clk(vga_clk), .rst(reset), .din(up), .level(lvl_up), .rise(rise_up)
    );
    btn_sync_edge u_sync_left (
        .clk(vga_clk), .rst(reset), .din(left), .level(lvl_left), .rise(rise_left)
    );
    btn_sync_edge u_sync_down (
        .clk(vga_clk), .rst(reset), .din(down), .level(lvl_down), .rise(rise_down)
    );
    btn_sync_edge u_sync_right (
        .clk(vga_clk), .rst(reset), .din(right), .level(lvl_right), .rise(rise_right)
    );
    btn_sync_edge u_sync_so (
        .clk(vga_clk), .rst(reset), .din(start_over), .level(lvl_so), .rise(rise_so)
    );

    assign unused_sync = &{lvl_up, lvl_left, lvl_right, lvl_so, rise_down};

    // Registered detect of the vs falling edge marks the start of blanking.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vs_d        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vs_d        <= vs;
            frame_start <= vs_d & ~vs;
        end
    end

    // Gravity period selection; >= keeps a long count from overshooting when
    // switching from normal to fast speed.
    always_comb begin
        grav_lim = lvl_down ? FAST_LIM : GRAV_LIM;
        grav_due = (grav_cnt >= grav_lim);
    end

    // Scheduler FSM with pending flags, gravity counter and registered outputs.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ref_x      <= X_START_V;
            ref_y      <= Y_START_V;
            grav_cnt   <= '0;
            pend_rot   <= 1'b0;
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            rotate     <= 1'b0;
            lock       <= 1'b0;
            spawn      <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            rotate <= 1'b0;
            lock   <= 1'b0;
            spawn  <= 1'b0;

            // Button edges latch until the next MOVE; ignored once the game is over.
            if (state != OVER) begin
                if (rise_up)    pend_rot   <= 1'b1;
                if (rise_left)  pend_left  <= 1'b1;
                if (rise_right) pend_right <= 1'b1;
            end

            if (rise_so) begin
                state     <= SPAWN;
                game_over <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_start) state <= MOVE;
                    end
                    MOVE: begin
                        if (pend_rot) begin
                            if (!blk_rot) rotate <= 1'b1;
                        end else if (pend_left) begin
                            if ((ref_x >= X_MIN_V + STEP_V) && !blk_left)
                                ref_x <= ref_x - STEP_V;
                        end else if (pend_right) begin
                            if ((ref_x + STEP_V <= X_MAX_V) && !blk_right)
                                ref_x <= ref_x + STEP_V;
                        end
                        pend_rot   <= 1'b0;
                        pend_left  <= 1'b0;
                        pend_right <= 1'b0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        state <= FALL;
                    end
                    FALL: begin
                        if (grav_due) begin
                            grav_cnt <= '0;
                            if (!blk_below) begin
                                ref_y <= ref_y + STEP_V;
                                state <= IDLE;
                            end else begin
                                lock  <= 1'b1;
                                state <= LOCK;
                            end
                        end else begin
                            grav_cnt <= grav_cnt + 8'd1;
                            state    <= IDLE;
                        end
                    end
                    LOCK: begin
                        if (ref_y == Y_START_V) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            state <= WAITCLR;
                        end
                    end
                    WAITCLR: begin
                        if (!clear) state <= SPAWN;
                    end
                    SPAWN: begin
                        ref_x      <= X_START_V;
                        ref_y      <= Y_START_V;
                        grav_cnt   <= '0;
                        pend_rot   <= 1'b0;
                        pend_left  <= 1'b0;
                        pend_right <= 1'b0;
                        spawn      <= 1'b1;
                        state      <= IDLE;
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
